// File: rtl/jpeg_idct_transpose_rd_if.sv
// Output stream of the IDCT transpose read sequencer: one coefficient per beat,
// valid/accept handshake, with the output-order index and an end-of-block flag.
interface jpeg_idct_transpose_rd_if;
    logic        valid;
    logic [15:0] data;
    logic [5:0]  idx;
    logic        last;
    logic        accept;

    modport master (
        output valid,
        output data,
        output idx,
        output last,
        input  accept
    );

    modport slave (
        input  valid,
        input  data,
        input  idx,
        input  last,
        output accept
    );
endinterface

// File: rtl/jpeg_idct_transpose_rd.sv
// Read-side sequencer for the IDCT 8x8 transpose buffer.
// Walks the 64 RAM entries of a completed block in column-major (TRANSPOSE=1)
// or raster (TRANSPOSE=0) order, hides the RAM's one-cycle read latency behind
// a 2-entry skid FIFO and streams the coefficients out at one beat per cycle.

// Simulation-only checker for the skid FIFO occupancy.
module jpeg_idct_transpose_rd_chk (
    input logic       clk_i,
    input logic       rst_i,
    input logic [1:0] fifo_cnt,
    input logic       push,
    input logic       pop
);
    // The read credit must guarantee room for every returning read.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(fifo_cnt == 2'd2 && push && !pop));

    // Occupancy never exceeds the two physical entries.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_i)
        fifo_cnt != 2'd3);
endmodule

module jpeg_idct_transpose_rd #(
    parameter bit TRANSPOSE = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic [5:0]               ram_addr_o,
    output logic                     ram_rd_o,
    input  logic [15:0]              ram_data_i,
    jpeg_idct_transpose_rd_if.master outport,
    output logic                     done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic [6:0]  rd_cnt_r;        // reads issued in this block, saturates at 64
    logic [5:0]  out_cnt_r;       // beats transferred in this block
    logic        inflight_r;      // a read was issued last cycle, data on ram_data_i now
    logic [15:0] fifo_mem_r [2];
    logic        fifo_wr_ptr_r;
    logic        fifo_rd_ptr_r;
    logic [1:0]  fifo_cnt_r;
    logic        done_r;

    logic        start_acc_s;
    logic        head_vld_s;
    logic [15:0] head_data_s;
    logic        pop_s;
    logic        push_s;
    logic        last_pop_s;
    logic [2:0]  credit_s;
    logic        issue_s;
    logic [5:0]  map_addr_s;

    // Column-major walk swaps the row and column halves of the linear counter.
    function automatic logic [5:0] map_addr(input logic [5:0] cnt);
        logic [5:0] addr;
        if (TRANSPOSE) begin
            addr = {cnt[2:0], cnt[5:3]};
        end else begin
            addr = cnt;
        end
        return addr;
    endfunction

    // Head of the stream: FIFO entry when one is stored, otherwise the RAM data
    // arriving this cycle so the first beat appears without an extra cycle.
    always_comb begin
        head_vld_s  = 1'b0;
        head_data_s = 16'd0;
        if (fifo_cnt_r != 2'd0) begin
            head_vld_s  = 1'b1;
            head_data_s = fifo_mem_r[fifo_rd_ptr_r];
        end else if (inflight_r) begin
            head_vld_s  = 1'b1;
            head_data_s = ram_data_i;
        end else begin
            head_vld_s  = 1'b0;
            head_data_s = 16'd0;
        end
    end

    assign pop_s       = head_vld_s && outport.accept;
    assign push_s      = inflight_r;
    assign last_pop_s  = pop_s && (out_cnt_r == 6'd63);
    assign start_acc_s = (state_r == ST_IDLE) && start_i;
    assign map_addr_s  = map_addr(rd_cnt_r[5:0]);

    // Read issue: a new read is allowed only while fewer than two results would
    // be waiting after this cycle's pop, which keeps the skid FIFO from overflowing.
    always_comb begin
        credit_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s  = 1'b0;
        if ((state_r == ST_READ) && (rd_cnt_r[6] == 1'b0) && (credit_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic of the block sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s && (rd_cnt_r == 7'd63)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read and output counters, restarted for every accepted block.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_r   <= 7'd0;
            out_cnt_r  <= 6'd0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (start_acc_s) begin
                rd_cnt_r  <= 7'd0;
                out_cnt_r <= 6'd0;
            end else begin
                if (issue_s) begin
                    rd_cnt_r <= rd_cnt_r + 7'd1;
                end
                if (pop_s) begin
                    out_cnt_r <= out_cnt_r + 6'd1;
                end
            end
        end
    end

    // Skid FIFO: every returning read is written, the head advances per transfer.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fifo_mem_r[0] <= 16'd0;
            fifo_mem_r[1] <= 16'd0;
            fifo_wr_ptr_r <= 1'b0;
            fifo_rd_ptr_r <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[fifo_wr_ptr_r] <= ram_data_i;
                fifo_wr_ptr_r             <= ~fifo_wr_ptr_r;
            end
            if (pop_s) begin
                fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Block-complete pulse, one cycle after the final beat leaves.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_pop_s && (state_r == ST_DRAIN);
        end
    end

    assign busy_o         = (state_r != ST_IDLE);
    assign done_o         = done_r;
    assign ram_rd_o       = issue_s;
    assign ram_addr_o     = issue_s ? map_addr_s : 6'd0;
    assign outport.valid  = head_vld_s;
    assign outport.data   = head_data_s;
    assign outport.idx    = out_cnt_r;
    assign outport.last   = head_vld_s && (out_cnt_r == 6'd63);

    jpeg_idct_transpose_rd_chk u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .fifo_cnt (fifo_cnt_r),
        .push     (push_s),
        .pop      (pop_s)
    );

endmodule

// File: tb/tb_jpeg_idct_transpose_rd.sv
// Bench for jpeg_idct_transpose_rd: a transposing and a raster instance run in
// lockstep from one start/accept; each beat is compared with the coefficient
// the block ordering rules select from a shared RAM image.
module tb_jpeg_idct_transpose_rd;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        start_s;
    logic        acc_s;
    logic [1:0]  busy_s;
    logic [1:0]  rd_s;
    logic [1:0]  done_s;
    logic [5:0]  addr0_s, addr1_s;
    logic [15:0] rdata0_s = 16'd0;
    logic [15:0] rdata1_s = 16'd0;
    logic [15:0] ram_mem [64];

    jpeg_idct_transpose_rd_if ob0 ();
    jpeg_idct_transpose_rd_if ob1 ();
    assign ob0.accept = acc_s;
    assign ob1.accept = acc_s;

    logic [1:0]  vld_s, last_s;
    logic [15:0] odata_s [2];
    logic [5:0]  oidx_s [2];
    assign vld_s      = {ob1.valid, ob0.valid};
    assign last_s     = {ob1.last, ob0.last};
    assign odata_s[0] = ob0.data;
    assign odata_s[1] = ob1.data;
    assign oidx_s[0]  = ob0.idx;
    assign oidx_s[1]  = ob1.idx;

    jpeg_idct_transpose_rd #(.TRANSPOSE(1'b1)) u_dut_t (
        .clk_i(clk_s), .rst_i(rst_s), .start_i(start_s), .busy_o(busy_s[0]),
        .ram_addr_o(addr0_s), .ram_rd_o(rd_s[0]), .ram_data_i(rdata0_s),
        .outport(ob0), .done_o(done_s[0]));

    jpeg_idct_transpose_rd #(.TRANSPOSE(1'b0)) u_dut_r (
        .clk_i(clk_s), .rst_i(rst_s), .start_i(start_s), .busy_o(busy_s[1]),
        .ram_addr_o(addr1_s), .ram_rd_o(rd_s[1]), .ram_data_i(rdata1_s),
        .outport(ob1), .done_o(done_s[1]));

    always #5 clk_s = ~clk_s;

    int cyc = 0;
    always @(posedge clk_s) cyc <= cyc + 1;

    // Synchronous-read RAM image shared by both instances.
    always @(posedge clk_s) begin
        if (rd_s[0]) rdata0_s <= ram_mem[addr0_s];
        if (rd_s[1]) rdata1_s <= ram_mem[addr1_s];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int blk_seq  = 0;
    int start_cyc = 0;
    int beat [2];
    int rd_cnt [2];
    int done_cnt [2];
    int last_pop_cyc [2];
    int first_vld_cyc [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference ordering: instance 0 walks columns, instance 1 walks rows.
    function automatic int exp_addr(int inst, int k);
        if (inst == 0) return (k % 8) * 8 + k / 8;
        return k;
    endfunction

    // Stream monitor / scoreboard.
    initial begin
        int seen_seq;
        int k;
        bit hold [2];
        logic [15:0] hold_data [2];
        logic [5:0]  hold_idx [2];
        seen_seq = 0;
        for (int i = 0; i < 2; i++) begin
            beat[i] = 0; rd_cnt[i] = 0; done_cnt[i] = 0;
            last_pop_cyc[i] = -100; first_vld_cyc[i] = -1; hold[i] = 1'b0;
            hold_data[i] = 16'd0; hold_idx[i] = 6'd0;
        end
        forever begin
            @(negedge clk_s);
            if (blk_seq != seen_seq) begin
                for (int i = 0; i < 2; i++) begin
                    beat[i] = 0; rd_cnt[i] = 0; first_vld_cyc[i] = -1;
                end
                seen_seq = blk_seq;
            end
            for (int i = 0; i < 2; i++) begin
                if (!rst_s) begin
                    hold[i] = 1'b0;
                end else begin
                    if (rd_s[i]) rd_cnt[i]++;
                    if (hold[i]) begin
                        check_eq($sformatf("hold_valid%0d", i), vld_s[i], 1);
                        check_eq($sformatf("hold_data%0d", i), odata_s[i], hold_data[i]);
                        check_eq($sformatf("hold_idx%0d", i), oidx_s[i], hold_idx[i]);
                    end
                    if (vld_s[i] && first_vld_cyc[i] < 0) first_vld_cyc[i] = cyc;
                    if (vld_s[i] && acc_s) begin
                        k = beat[i];
                        if (k > 63) begin
                            check_eq($sformatf("extra_beat%0d", i), k, 63);
                        end else begin
                            check_eq($sformatf("data%0d_b%0d", i, k), odata_s[i], ram_mem[exp_addr(i, k)]);
                            check_eq($sformatf("idx%0d_b%0d", i, k), oidx_s[i], k);
                            check_eq($sformatf("last%0d_b%0d", i, k), last_s[i], (k == 63));
                        end
                        beat[i]++;
                        last_pop_cyc[i] = cyc;
                    end
                    hold[i]      = vld_s[i] && !acc_s;
                    hold_data[i] = odata_s[i];
                    hold_idx[i]  = oidx_s[i];
                    if (done_s[i]) begin
                        done_cnt[i]++;
                        check_eq($sformatf("done_lat%0d", i), cyc - last_pop_cyc[i], 1);
                    end
                    if (rd_s[i]) check_eq($sformatf("outstanding%0d", i), (rd_cnt[i] - beat[i]) <= 2, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    // Raise start for the current cycle and open a new block in the scoreboard.
    task automatic start_block();
        start_s   = 1'b1;
        start_cyc = cyc;
        blk_seq++;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while ((done_cnt[0] < target || done_cnt[1] < target) && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_timeout", n < budget, 1);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("beats%0d", i), beat[i], 64);
            check_eq($sformatf("done_cnt%0d", i), done_cnt[i], target);
        end
    endtask

    task automatic wait_beat(input int b);
        int n;
        n = 0;
        while (beat[0] < b && n < 500) begin
            tick();
            n++;
        end
        check_eq("beat_timeout", n < 500, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bit held;
        rst_s = 1'b0; start_s = 1'b0; acc_s = 1'b1;
        for (int a = 0; a < 64; a++) ram_mem[a] = 16'(a);
        repeat (3) @(posedge clk_s);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_valid%0d", i), vld_s[i], 0);
            check_eq($sformatf("rst_busy%0d", i), busy_s[i], 0);
            check_eq($sformatf("rst_done%0d", i), done_s[i], 0);
            check_eq($sformatf("rst_rd%0d", i), rd_s[i], 0);
            check_eq($sformatf("rst_data%0d", i), odata_s[i], 0);
            check_eq($sformatf("rst_last%0d", i), last_s[i], 0);
        end
        check_eq("rst_addr0", addr0_s, 0);
        check_eq("rst_addr1", addr1_s, 0);
        rst_s = 1'b1;
        tick();

        // Full-rate block, timing of valid/busy/done.
        start_block();
        check_eq("busy_c0", busy_s, 2'b00);
        for (int rel = 1; rel <= 67; rel++) begin
            tick();
            start_s = 1'b0;
            if (rel == 1 || rel == 65) check_eq($sformatf("busy_c%0d", rel), busy_s, 2'b11);
            if (rel == 65) check_eq("done_c65", done_s, 2'b00);
            if (rel == 66) begin
                check_eq("busy_c66", busy_s, 2'b00);
                check_eq("done_c66", done_s, 2'b11);
            end
        end
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("first_valid%0d", i), first_vld_cyc[i] - start_cyc, 2);
            check_eq($sformatf("beats%0d", i), beat[i], 64);
            check_eq($sformatf("done_cnt%0d", i), done_cnt[i], 1);
        end

        // Accept held low from the start: only two reads go out.
        acc_s = 1'b0;
        start_block();
        tick();
        start_s = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("stall_reads%0d", i), rd_cnt[i], 2);
            check_eq($sformatf("stall_valid%0d", i), vld_s[i], 1);
            check_eq($sformatf("stall_data%0d", i), odata_s[i], 0);
            check_eq($sformatf("stall_idx%0d", i), oidx_s[i], 0);
        end
        check_eq("stall_rd_idle", rd_s, 2'b00);
        acc_s = 1'b1;
        wait_done(2, 300);

        // Alternating accept with a 10-cycle stall at beat 5, random RAM.
        for (int a = 0; a < 64; a++) ram_mem[a] = 16'($urandom);
        tick();
        start_block();
        tick();
        start_s = 1'b0;
        held = 1'b0;
        n = 0;
        while ((done_cnt[0] < 3 || done_cnt[1] < 3) && n < 600) begin
            if (beat[0] == 5 && !held) begin
                acc_s = 1'b0;
                repeat (10) tick();
                held = 1'b1;
            end
            acc_s = (n % 2 == 0);
            tick();
            n++;
        end
        acc_s = 1'b1;
        wait_done(3, 50);

        // Random accept over two blocks with fresh random contents.
        for (int blk = 0; blk < 2; blk++) begin
            for (int a = 0; a < 64; a++) ram_mem[a] = 16'($urandom);
            tick();
            start_block();
            tick();
            start_s = 1'b0;
            n = 0;
            while (done_cnt[0] < 4 + blk && n < 600) begin
                acc_s = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            acc_s = 1'b1;
            wait_done(4 + blk, 50);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        for (int a = 0; a < 64; a++) ram_mem[a] = 16'(a);
        base = done_cnt[0];
        tick();
        start_block();
        tick();
        start_s = 1'b0;
        wait_beat(20);
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        n = 0;
        while (done_s[0] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_eq("done_seen", n < 200, 1);
        check_eq("busy_start_beats", beat[0], 64);
        start_block();
        tick();
        start_s = 1'b0;
        wait_done(base + 2, 200);
        check_eq("b2b_first_valid", first_vld_cyc[0] - start_cyc, 2);

        // Asynchronous reset in the middle of a block.
        base = done_cnt[0];
        tick();
        start_block();
        tick();
        start_s = 1'b0;
        wait_beat(30);
        #3;
        rst_s = 1'b0;
        #1;
        check_eq("arst_valid", vld_s, 2'b00);
        check_eq("arst_busy", busy_s, 2'b00);
        check_eq("arst_done", done_s, 2'b00);
        repeat (2) @(posedge clk_s);
        #1;
        rst_s = 1'b1;
        tick();
        check_eq("arst_no_done", done_cnt[0], base);
        start_block();
        tick();
        start_s = 1'b0;
        wait_done(base + 1, 200);
        check_eq("arst_first_valid", first_vld_cyc[1] - start_cyc, 2);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
